sobel_stream_filter: RTL

SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

---
 rtl/sobel_pkg.sv | 26 ++
 rtl/sobel_line_buffer.sv | 34 +++
 rtl/sobel_stream_filter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// ============================================================================
// Module : sobel_pkg
// Desc   : Shared FSM states, 3x3 Sobel kernel weights and counter sizing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } sobel_state_t;

   localparam int c_K_EDGE = 1;
   localparam int c_K_MID  = 2;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sobel_line_buffer.sv
// ============================================================================
// Module : sobel_line_buffer
// Desc   : DEPTH-stage shift register; output is the sample DEPTH enables ago.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sobel_line_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Storage is deliberately left without reset.
   always_ff @(posedge clk) begin
      if (i_en) begin
         r_mem[0] <= i_din;
         for (int i = 1; i < DEPTH; i++) begin
            r_mem[i] <= r_mem[i-1];
         end
      end
   end

   assign o_dout = r_mem[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sobel_stream_filter.sv
// ============================================================================
// Module : sobel_stream_filter
// Desc   : Streaming 3x3 Sobel edge magnitude; optional threshold via
//          SOBEL_THRESH_EN (adds thresh_i, binarises edge_o).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sobel_stream_filter
   import sobel_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [PIX_W-1:0] pixel_i,
   input  logic             pixel_valid_i,
   output logic             pixel_ready_o,
   output logic [PIX_W-1:0] edge_o,
   output logic             edge_valid_o,
   input  logic             edge_ready_i,
`ifdef SOBEL_THRESH_EN
   input  logic [PIX_W-1:0] thresh_i,
`endif
   output logic             busy_o,
   output logic             done_o
);

   localparam int c_COL_W = cnt_width(IMG_W);
   localparam int c_ROW_W = cnt_width(IMG_H);
   localparam int c_ACC_W = PIX_W + 3;
   localparam logic signed [c_ACC_W-1:0] c_W_EDGE = c_ACC_W'(c_K_EDGE);
   localparam logic signed [c_ACC_W-1:0] c_W_MID  = c_ACC_W'(c_K_MID);

   sobel_state_t        r_state, w_next;
   logic [c_COL_W-1:0]  r_col;
   logic [c_ROW_W-1:0]  r_row;
   logic                r_edge_valid;
   logic [PIX_W-1:0]    r_edge;
   logic [PIX_W-1:0]    r_a [3];
   logic [PIX_W-1:0]    r_b [3];
   logic [PIX_W-1:0]    w_new [3];
   logic [PIX_W-1:0]    w_lb0, w_lb1;
   logic                w_ready, w_accept, w_last, w_emit;
   logic signed [c_ACC_W-1:0] w_gx, w_gy;
   logic [c_ACC_W-1:0]  w_abs_x, w_abs_y;
   logic [c_ACC_W:0]    w_mag;
   logic [PIX_W-1:0]    w_sat, w_result;

   function automatic logic signed [c_ACC_W-1:0] sx(input logic [PIX_W-1:0] p);
      return $signed({3'b000, p});
   endfunction

   assign w_ready  = (r_state == ST_RUN) && (!r_edge_valid || edge_ready_i);
   assign w_accept = w_ready && pixel_valid_i;
   assign w_last   = (r_col == c_COL_W'(IMG_W-1)) && (r_row == c_ROW_W'(IMG_H-1));
   assign w_emit   = w_accept && (r_row >= c_ROW_W'(2)) && (r_col >= c_COL_W'(2));

   sobel_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb0 (
      .clk(clk_i), .i_en(w_accept), .i_din(pixel_i), .o_dout(w_lb0)
   );
   sobel_line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb1 (
      .clk(clk_i), .i_en(w_accept), .i_din(w_lb0), .o_dout(w_lb1)
   );

   // Newest column of the window: rows r-2, r-1, r at the current column.
   assign w_new[0] = w_lb1;
   assign w_new[1] = w_lb0;
   assign w_new[2] = pixel_i;

   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         for (int i = 0; i < 3; i++) begin
            r_b[i] <= r_a[i];
            r_a[i] <= w_new[i];
         end
      end
   end

   // Window taps pRC: R from oldest row, C from oldest column.
   always_comb begin
      w_gx = (sx(w_new[0]) * c_W_EDGE + sx(w_new[1]) * c_W_MID + sx(w_new[2]) * c_W_EDGE)
           - (sx(r_b[0])   * c_W_EDGE + sx(r_b[1])   * c_W_MID + sx(r_b[2])   * c_W_EDGE);
      w_gy = (sx(r_b[2]) * c_W_EDGE + sx(r_a[2]) * c_W_MID + sx(w_new[2]) * c_W_EDGE)
           - (sx(r_b[0]) * c_W_EDGE + sx(r_a[0]) * c_W_MID + sx(w_new[0]) * c_W_EDGE);
      w_abs_x = w_gx[c_ACC_W-1] ? c_ACC_W'(-w_gx) : c_ACC_W'(w_gx);
      w_abs_y = w_gy[c_ACC_W-1] ? c_ACC_W'(-w_gy) : c_ACC_W'(w_gy);
      w_mag   = {1'b0, w_abs_x} + {1'b0, w_abs_y};
      w_sat   = (|w_mag[c_ACC_W:PIX_W]) ? {PIX_W{1'b1}} : w_mag[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
      w_result = (w_sat >= thresh_i) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
      w_result = w_sat;
`endif
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (start_i) w_next = ST_RUN;
         ST_RUN:   if (w_accept && w_last) w_next = ST_FLUSH;
         ST_FLUSH: if (!r_edge_valid || edge_ready_i) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_edge       <= '0;
         r_edge_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && start_i) begin
            r_col <= '0;
            r_row <= '0;
         end else if (w_accept) begin
            if (w_last) begin
               r_col <= '0;
               r_row <= '0;
            end else if (r_col == c_COL_W'(IMG_W-1)) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if (w_emit) begin
            r_edge       <= w_result;
            r_edge_valid <= 1'b1;
         end else if (edge_ready_i) begin
            r_edge_valid <= 1'b0;
         end
      end
   end

   assign pixel_ready_o = w_ready;
   assign edge_o        = r_edge;
   assign edge_valid_o  = r_edge_valid;
   assign busy_o        = (r_state == ST_RUN) || (r_state == ST_FLUSH);
   assign done_o        = (r_state == ST_DONE);

endmodule

`default_nettype wire
